// File: rtl/traceback_unit_if.sv
// ============================================================================
// Module  : traceback_unit_if
// Purpose : Symbol-RAM read port plus alignment-move output stream of the
//           Needleman-Wunsch traceback stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface traceback_unit_if #(
  parameter int BIT_ADDR = 8
) ();
  logic                rd_en;
  logic [BIT_ADDR:0]   rd_i;
  logic [BIT_ADDR:0]   rd_j;
  logic [2:0]          rd_symbol;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_move;
  logic [BIT_ADDR:0]   out_i;
  logic [BIT_ADDR:0]   out_j;

  modport master (
    output rd_en, rd_i, rd_j, out_valid, out_move, out_i, out_j,
    input  rd_symbol, out_ready
  );

  modport slave (
    input  rd_en, rd_i, rd_j, out_valid, out_move, out_i, out_j,
    output rd_symbol, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/traceback_unit.sv
// ============================================================================
// Module  : traceback_unit
// Purpose : Walks the direction-symbol matrix from (N,N) back to (0,0),
//           emitting one alignment move per step over a valid/ready stream.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module traceback_unit #(
  parameter int N        = 128,
  parameter int BIT_ADDR = $clog2(N + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BIT_ADDR+1:0]    step_cnt,
  traceback_unit_if.master       bus
);

  localparam logic [1:0]          C_MOVE_DIAG = 2'b00;
  localparam logic [1:0]          C_MOVE_UP   = 2'b01;
  localparam logic [1:0]          C_MOVE_LEFT = 2'b10;
  localparam logic [BIT_ADDR:0]   C_IDX_N     = (BIT_ADDR + 1)'(N);
  localparam logic [BIT_ADDR:0]   C_IDX_ZERO  = '0;
  localparam logic [BIT_ADDR:0]   C_IDX_ONE   = (BIT_ADDR + 1)'(1);
  localparam logic [BIT_ADDR+1:0] C_STEP_ONE  = (BIT_ADDR + 2)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIT_ADDR:0]     r_i;
  logic [BIT_ADDR:0]     r_j;
  logic [BIT_ADDR:0]     w_i_nxt;
  logic [BIT_ADDR:0]     w_j_nxt;
  logic [1:0]            r_move;
  logic [1:0]            w_move_nxt;
  logic                  r_err;
  logic [BIT_ADDR+1:0]   r_step_cnt;
  logic                  w_start_acc;
  logic                  w_move_ld;
  logic                  w_xfer;
  logic                  w_err_set;
  logic                  w_rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_move_ld   = 1'b0;
    w_move_nxt  = r_move;
    w_xfer      = 1'b0;
    w_err_set   = 1'b0;
    w_rd_en     = 1'b0;
    // Post-transfer coordinates; an axis already at 0 is never decremented
    w_i_nxt     = (r_move == C_MOVE_LEFT) ? r_i : r_i - C_IDX_ONE;
    w_j_nxt     = (r_move == C_MOVE_UP)   ? r_j : r_j - C_IDX_ONE;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_i == C_IDX_ZERO && r_j == C_IDX_ZERO) begin
          w_state_nxt = S_FIN;
        end else if (r_i == C_IDX_ZERO) begin
          w_move_ld   = 1'b1;
          w_move_nxt  = C_MOVE_LEFT;
          w_state_nxt = S_EMIT;
        end else if (r_j == C_IDX_ZERO) begin
          w_move_ld   = 1'b1;
          w_move_nxt  = C_MOVE_UP;
          w_state_nxt = S_EMIT;
        end else begin
          w_rd_en     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rd_symbol == 3'b000) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end else begin
          w_move_ld   = 1'b1;
          w_move_nxt  = bus.rd_symbol[0] ? C_MOVE_DIAG :
                        bus.rd_symbol[1] ? C_MOVE_UP   : C_MOVE_LEFT;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = (w_i_nxt == C_IDX_ZERO && w_j_nxt == C_IDX_ZERO) ? S_FIN : S_READ;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i        <= '0;
      r_j        <= '0;
      r_move     <= C_MOVE_DIAG;
      r_err      <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_i        <= C_IDX_N;
        r_j        <= C_IDX_N;
        r_err      <= 1'b0;
        r_step_cnt <= '0;
      end
      if (w_move_ld) r_move <= w_move_nxt;
      if (w_err_set) r_err  <= 1'b1;
      if (w_xfer) begin
        r_i        <= w_i_nxt;
        r_j        <= w_j_nxt;
        r_step_cnt <= r_step_cnt + C_STEP_ONE;
      end
    end
  end

  assign bus.rd_en     = w_rd_en;
  assign bus.rd_i      = r_i;
  assign bus.rd_j      = r_j;
  assign bus.out_valid = (r_state == S_EMIT);
  assign bus.out_move  = r_move;
  assign bus.out_i     = r_i;
  assign bus.out_j     = r_j;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_FIN);
  assign err           = r_err;
  assign step_cnt      = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_traceback_unit.sv
// ============================================================================
// Module  : tb_traceback_unit
// Purpose : Randomised and directed bench for traceback_unit against a
//           path-walking reference model of the traceback rules.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traceback_unit;
  localparam int N  = 4;
  localparam int BA = 3;

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            err;
  logic [BA+1:0]   step_cnt;

  traceback_unit_if #(.BIT_ADDR(BA)) bus ();

  traceback_unit #(.N(N), .BIT_ADDR(BA)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .step_cnt (step_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Synchronous symbol RAM: data valid the cycle after rd_en, zero otherwise
  logic [2:0] ram [0:N][0:N];
  always @(posedge clk) bus.rd_symbol <= bus.rd_en ? ram[bus.rd_i][bus.rd_j] : 3'b000;

  int total = 0;
  int bad   = 0;

  int exp_move[$];
  int exp_i[$];
  int exp_j[$];
  int exp_ri[$];
  int exp_rj[$];
  bit exp_err;
  int exp_base;

  function automatic void fill(input logic [2:0] v);
    for (int a = 0; a <= N; a++)
      for (int b = 0; b <= N; b++)
        ram[a][b] = v;
  endfunction

  // Walk the path by the traceback rules; moves 0=diag 1=up 2=left
  function automatic void build_model();
    int i = N;
    int j = N;
    int m;
    logic [2:0] s;
    exp_move.delete(); exp_i.delete(); exp_j.delete();
    exp_ri.delete();   exp_rj.delete();
    exp_err  = 1'b0;
    exp_base = 0;
    while (!(i == 0 && j == 0)) begin
      if (i == 0) begin
        exp_move.push_back(2); exp_i.push_back(i); exp_j.push_back(j);
        j = j - 1; exp_base += 2;
      end else if (j == 0) begin
        exp_move.push_back(1); exp_i.push_back(i); exp_j.push_back(j);
        i = i - 1; exp_base += 2;
      end else begin
        exp_ri.push_back(i); exp_rj.push_back(j);
        s = ram[i][j];
        if (s == 3'b000) begin
          exp_err = 1'b1; exp_base += 2;
          break;
        end
        m = s[0] ? 0 : (s[1] ? 1 : 2);
        exp_move.push_back(m); exp_i.push_back(i); exp_j.push_back(j);
        if (m != 2) i = i - 1;
        if (m != 1) j = j - 1;
        exp_base += 3;
      end
    end
  endfunction

  // mode: 0 ready always, 1 five-cycle stall at first EMIT, 2 random ready
  task automatic run_trace(input string name, input int mode, input bit poke);
    int  done_k = 0;
    int  stalls = 0;
    int  mi = 0;
    int  ri = 0;
    bit  held = 1'b0;
    bit  rdy;
    logic [1:0]  hm;
    logic [BA:0] hi, hj;
    build_model();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (poke && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if (k == 1) begin
        total++;
        if (err !== 1'b0 || step_cnt !== '0 || busy !== 1'b1)
          $display("FAIL %s start_clear: err=%0d step_cnt=%0d busy=%0d, want 0 0 1",
                   name, err, step_cnt, busy);
        if (err !== 1'b0 || step_cnt !== '0 || busy !== 1'b1) bad++;
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (bus.rd_en === 1'b1) begin
        total++;
        if (ri >= exp_ri.size() || bus.out_valid !== 1'b0 ||
            bus.rd_i !== exp_ri[ri] || bus.rd_j !== exp_rj[ri]) begin
          bad++;
          $display("FAIL %s rd_addr[%0d]: got (%0d,%0d) valid=%0d, want (%0d,%0d) of %0d reads",
                   name, ri, bus.rd_i, bus.rd_j, bus.out_valid,
                   (ri < exp_ri.size()) ? exp_ri[ri] : -1,
                   (ri < exp_rj.size()) ? exp_rj[ri] : -1, exp_ri.size());
        end
        ri++;
      end
      if (bus.out_valid === 1'b1) begin
        if (held) begin
          total++;
          if (bus.out_move !== hm || bus.out_i !== hi || bus.out_j !== hj) begin
            bad++;
            $display("FAIL %s stall_hold: got move=%0d (%0d,%0d), want move=%0d (%0d,%0d)",
                     name, bus.out_move, bus.out_i, bus.out_j, hm, hi, hj);
          end
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (stalls >= 5);
          default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        bus.out_ready = rdy;
        if (rdy) begin
          held = 1'b0;
          total++;
          if (mi >= exp_move.size() || bus.out_move !== exp_move[mi] ||
              bus.out_i !== exp_i[mi] || bus.out_j !== exp_j[mi]) begin
            bad++;
            $display("FAIL %s move[%0d]: got move=%0d (%0d,%0d), want move=%0d (%0d,%0d) of %0d moves",
                     name, mi, bus.out_move, bus.out_i, bus.out_j,
                     (mi < exp_move.size()) ? exp_move[mi] : -1,
                     (mi < exp_i.size()) ? exp_i[mi] : -1,
                     (mi < exp_j.size()) ? exp_j[mi] : -1, exp_move.size());
          end
          mi++;
        end else begin
          held = 1'b1;
          hm = bus.out_move; hi = bus.out_i; hj = bus.out_j;
          stalls++;
        end
      end else begin
        bus.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    start = 1'b0;
    bus.out_ready = 1'b1;

    total++;
    if (done_k == 0) begin
      bad++;
      $display("FAIL %s timeout: no done within 200 cycles, want done", name);
    end
    total++;
    if (done_k != 1 + exp_base + stalls) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d, want %0d", name, done_k, 1 + exp_base + stalls);
    end
    total++;
    if (mi != exp_move.size() || ri != exp_ri.size()) begin
      bad++;
      $display("FAIL %s counts: got moves=%0d reads=%0d, want moves=%0d reads=%0d",
               name, mi, ri, exp_move.size(), exp_ri.size());
    end
    total++;
    if (step_cnt !== exp_move.size() || err !== exp_err || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s final: got step_cnt=%0d err=%0d busy=%0d, want %0d %0d 1",
               name, step_cnt, err, busy, exp_move.size(), exp_err);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== exp_err) begin
      bad++;
      $display("FAIL %s idle_after: got busy=%0d done=%0d err=%0d, want 0 0 %0d",
               name, busy, done, err, exp_err);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (bus.rd_en !== 1'b0 || bus.rd_i !== '0 || bus.rd_j !== '0 || bus.out_valid !== 1'b0 ||
        bus.out_move !== 2'b00 || bus.out_i !== '0 || bus.out_j !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || step_cnt !== '0) begin
      bad++;
      $display("FAIL %s reset_values: got rd_en=%0d rd=(%0d,%0d) valid=%0d move=%0d out=(%0d,%0d) busy=%0d done=%0d err=%0d step=%0d, want all 0",
               name, bus.rd_en, bus.rd_i, bus.rd_j, bus.out_valid, bus.out_move,
               bus.out_i, bus.out_j, busy, done, err, step_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_diag();
    fill(3'b001);
    run_trace("all_diag", 0, 1'b0);
  endtask

  task automatic test_up();
    fill(3'b010);
    run_trace("all_up", 0, 1'b0);
  endtask

  task automatic test_tie();
    fill(3'b001);
    ram[4][4] = 3'b111;
    run_trace("tie_111", 0, 1'b0);
  endtask

  task automatic test_stall();
    fill(3'b001);
    run_trace("stall5", 1, 1'b0);
  endtask

  task automatic test_error();
    fill(3'b001);
    ram[3][3] = 3'b000;
    run_trace("bad_symbol", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a <= N; a++)
        for (int b = 0; b <= N; b++) begin
          ram[a][b] = 3'($urandom_range(0, 7));
          if (ram[a][b] == 3'b000 && $urandom_range(0, 3) != 0) ram[a][b] = 3'b100;
        end
      run_trace($sformatf("random%0d", r), 2, 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    int  seen = 0;
    bit  hit  = 1'b0;
    fill(3'b001);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.out_valid === 1'b1) seen++;
      if (seen == 2) begin
        hit = 1'b1;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reset reach_emit2: got %0d EMIT cycles, want 2", seen);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset no_resume: got done=%0d busy=%0d, want 0 0", done, busy);
      end
    end
    run_trace("restart", 0, 1'b0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    fill(3'b001);
    test_reset();
    test_diag();
    test_up();
    test_tie();
    test_stall();
    test_error();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traceback_unit.md
# traceback_unit

Traceback stage of the Needleman-Wunsch datapath: runs after the matrix-filling phase completes and consumes the 3-bit direction symbols the max/score stage wrote into the symbol RAM. Starting at cell (N,N), it walks back to (0,0) one cell per step. Each step emits one alignment move (diagonal, up or left) over a valid/ready stream to the alignment output formatter. Boundary moves on row 0 and column 0 are generated internally without a RAM read.

## Interface
- N, 128, sequence length; the matrix spans indices 0..N on both axes
- BitAddr, $clog2(N+1), index width parameter; indices are carried on [BitAddr:0]
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; rst=0 forces the reset state immediately
- start  in  1  one-cycle request to begin traceback; ignored unless the FSM is in IDLE
- rd_en  out  1  symbol RAM read strobe
- rd_i, rd_j  out  BitAddr+1  symbol RAM read address (row, column)
- rd_symbol  in  3  RAM read data, valid exactly one cycle after rd_en; bit0=diag, bit1=up, bit2=left
- out_valid  out  1  move available
- out_ready  in  1  downstream accepts the move; a transfer occurs when out_valid and out_ready are both 1
- out_move  out  2  00=diag, 01=up, 10=left; 11 is never driven
- out_i, out_j  out  BitAddr+1  cell the move originates from
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when traceback ends, normally or on error
- err  out  1  sticky invalid-symbol flag; cleared by the next accepted start
- step_cnt  out  BitAddr+2  number of moves accepted in the current or last run

## Operation
- States: IDLE, READ, WAIT, EMIT, FIN.
- IDLE
  - On start: i=N, j=N, step_cnt=0, err=0, go to READ.
- READ
  - If i==0 and j==0: go to FIN. This case is unreachable at entry when N≥1.
  - If i==0: no RAM read; the move is forced to left; go to EMIT.
  - If j==0: no RAM read; the move is forced to up; go to EMIT.
  - Otherwise: rd_en=1, rd_i=i, rd_j=j; go to WAIT.
- WAIT
  - Capture rd_symbol.
  - Decode with priority diag > up > left, so ties such as 3'b011 and 3'b111 resolve to diag.
  - If rd_symbol==3'b000: set err=1 and go to FIN without emitting.
  - Otherwise go to EMIT.
- EMIT
  - out_valid=1; out_move, out_i and out_j are held stable until the transfer.
  - On transfer:
    - diag: i=i-1, j=j-1
    - up: i=i-1
    - left: j=j-1
    - step_cnt increments by 1.
  - After the transfer: if the new (i,j)==(0,0), go to FIN; else go to READ.
- FIN
  - done=1 for this cycle only, then go to IDLE.
  - err and step_cnt hold their values until the next accepted start.
- Arithmetic and ranges:
  - Index decrements are unsigned and never wrap, because a decrement on an axis equal to 0 is never selected.
  - step_cnt never exceeds 2N; the width BitAddr+2 covers this value.
- rd_en is 0 in every state except READ, and is never asserted while stalled in EMIT.
- A start that arrives while busy=1 is dropped and has no effect.

## Timing
- Reset values: rd_en=0, rd_i=0, rd_j=0, out_valid=0, out_move=00, out_i=0, out_j=0, busy=0, done=0, err=0, step_cnt=0, state=IDLE.
- Asserting rst=0 mid-run aborts the run: no done pulse is generated and a fresh start is required.
- The start edge is followed by READ in the next cycle, so the first rd_en appears 1 cycle after start.
- Interior step with out_ready held at 1: READ, WAIT, EMIT, for 3 cycles per move.
- Boundary step with out_ready held at 1: READ, EMIT, for 2 cycles per move.
- The done pulse occurs in the cycle immediately after the last transfer.
- Backpressure: each cycle with out_ready=0 in EMIT adds exactly one cycle; outputs remain stable throughout the stall.

## Test plan
- N=4, RAM fully 3'b001, start -> 4 diag moves from (4,4),(3,3),(2,2),(1,1); 12 cycles from first READ to last transfer; done; step_cnt=4; err=0.
- N=4, RAM fully 3'b010 (up) -> 4 up moves read from RAM at column j=4; then 4 forced left moves with rd_en=0; step_cnt=8; done.
- N=4, cell (4,4)=3'b111, others 3'b001 -> first out_move=00 (tie resolved to diag); the run completes with step_cnt=4.
- N=4, out_ready=0 for 5 cycles at the first EMIT -> out_valid=1 and out_move/out_i/out_j are unchanged for 5 cycles; rd_en=0 throughout; the total run is 5 cycles longer.
- N=4, cell (3,3)=3'b000, others diag -> exactly 1 move is emitted; err=1; done pulse; step_cnt=1; busy falls the cycle after done.
- rst=0 asserted during the second EMIT -> all outputs are at reset values in the same cycle; a following start restarts from (4,4) with step_cnt=0.
